// File: rtl/cache_def.sv
// Shared types for the cache controller and its main-memory backing store.
// Optional build macro used by the memory model: MAIN_MEM_PARITY_EN.
package cache_def;

   localparam int MEM_LINE_BITS = 128;
   localparam int MEM_IDX_BITS  = 10;

   typedef logic [MEM_LINE_BITS-1:0] cache_data_type;

   typedef struct packed {
      logic [MEM_IDX_BITS-1:0] addr;
      logic [MEM_IDX_BITS-1:0] wraddr;
      cache_data_type          data;
      logic                    rw;
      logic                    valid;
   } mem_req_type;

   typedef struct packed {
      logic [MEM_LINE_BITS:0] data;
      logic                   ready;
   } mem_data_type;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } mem_state_type;

   // Even parity over one memory line.
   function automatic logic line_parity(input cache_data_type line);
      return ^line;
   endfunction

endpackage

// File: rtl/main_mem_array.sv
// Single-port line store: synchronous write, registered read, one address.
module main_mem_array
   import cache_def::*;
#(
   parameter int DEPTH = 1024
)
(
   input  logic                    clk,
   input  logic                    we,
   input  logic                    re,
   input  logic [MEM_IDX_BITS-1:0] addr,
   input  cache_data_type          wdata,
   output cache_data_type          rdata
);

   cache_data_type mem_r [DEPTH];
   cache_data_type rdata_r;

   // Storage and read register carry no reset so contents survive rst_n.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr] <= wdata;
      end else if (re) begin
         rdata_r <= mem_r[addr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/main_mem_model.sv
// Fixed-latency main-memory model serving cache line fills and write-backs.
// Build with MAIN_MEM_PARITY_EN to drive even parity on mem_data.data[128].
module main_mem_model
   import cache_def::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 4
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  mem_req_type  mem_req,
   output mem_data_type mem_data
);

   localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

   mem_state_type           state_r;
   logic [3:0]              cnt_r;
   logic [MEM_IDX_BITS-1:0] addr_r;
   logic [MEM_IDX_BITS-1:0] wraddr_r;
   cache_data_type          wdata_r;
   logic                    rw_r;
   logic                    ready_r;
   cache_data_type          line_r;

   logic                    arr_we_s;
   logic                    arr_re_s;
   logic [MEM_IDX_BITS-1:0] arr_addr_s;
   cache_data_type          rd_line_s;
   logic                    parity_s;

   // Array port: the read lands on entry to RESP, the write commits leaving RESP.
   always_comb begin
      arr_we_s   = 1'b0;
      arr_re_s   = 1'b0;
      arr_addr_s = addr_r;
      if (rw_r) begin
         arr_addr_s = wraddr_r;
      end else begin
         arr_addr_s = addr_r;
      end
      if (state_r == RESP) begin
         arr_we_s = rw_r;
      end else begin
         arr_we_s = 1'b0;
      end
      if ((state_r == BUSY) && (cnt_r == LAST_CNT)) begin
         arr_re_s = ~rw_r;
      end else begin
         arr_re_s = 1'b0;
      end
   end

   main_mem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (arr_we_s),
      .re    (arr_re_s),
      .addr  (arr_addr_s),
      .wdata (wdata_r),
      .rdata (rd_line_s)
   );

   // Request FSM; ready is registered from RESP so the pulse sits in the following IDLE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         cnt_r    <= 4'd0;
         addr_r   <= '0;
         wraddr_r <= '0;
         wdata_r  <= '0;
         rw_r     <= 1'b0;
         ready_r  <= 1'b0;
         line_r   <= '0;
      end else begin
         ready_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (mem_req.valid) begin
                  addr_r   <= mem_req.addr;
                  wraddr_r <= mem_req.wraddr;
                  wdata_r  <= mem_req.data;
                  rw_r     <= mem_req.rw;
                  cnt_r    <= 4'd0;
                  state_r  <= BUSY;
               end else begin
                  state_r  <= IDLE;
               end
            end
            BUSY: begin
               cnt_r <= cnt_r + 4'd1;
               if (cnt_r == LAST_CNT) begin
                  state_r <= RESP;
               end else begin
                  state_r <= BUSY;
               end
            end
            RESP: begin
               ready_r <= 1'b1;
               line_r  <= rw_r ? wdata_r : rd_line_s;
               state_r <= IDLE;
            end
            default: begin
               cnt_r   <= 4'd0;
               state_r <= IDLE;
            end
         endcase
      end
   end

`ifdef MAIN_MEM_PARITY_EN
   assign parity_s = line_parity(line_r);
`else
   assign parity_s = 1'b0;
`endif

   assign mem_data = {parity_s, line_r, ready_r};

endmodule
